// File: rtl/cr_ib_flow_gate.sv
// Inbound AXI4-Stream flow gate: admission by masked external readies,
// optional whole-frame gating, DEPTH-entry elastic buffer and stall counter.
module cr_ib_flow_gate #(
    parameter int DATA_W     = 64,
    parameter int TID_W      = 1,
    parameter int TUSER_W    = 8,
    parameter int N_EXT      = 2,
    parameter int DEPTH      = 4,
    parameter int FRAME_MODE = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_tvalid,
    input  logic                         in_tlast,
    input  logic [TID_W-1:0]             in_tid,
    input  logic [DATA_W/8-1:0]          in_tstrb,
    input  logic [TUSER_W-1:0]           in_tuser,
    input  logic [DATA_W-1:0]            in_tdata,
    output logic                         in_tready,
    input  logic [N_EXT-1:0]             ext_tready,
    input  logic [N_EXT-1:0]             ext_mask,
    output logic                         out_tvalid,
    output logic                         out_tlast,
    output logic [TID_W-1:0]             out_tid,
    output logic [DATA_W/8-1:0]          out_tstrb,
    output logic [TUSER_W-1:0]           out_tuser,
    output logic [DATA_W-1:0]            out_tdata,
    input  logic                         out_tready,
    output logic                         stall_pulse,
    output logic [31:0]                  stall_cnt,
    input  logic                         cnt_clr,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int STRB_W = DATA_W / 8;
    localparam int LVL_W  = $clog2(DEPTH + 1);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int BEAT_W = 1 + TID_W + STRB_W + TUSER_W + DATA_W;

    logic [BEAT_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]  count_q, count_d;
    logic              in_frame_q, in_frame_d;
    logic [31:0]       stall_cnt_q, stall_cnt_d;

    logic gate_open_s, full_s, empty_s, admit_s, push_s, pop_s, stall_s;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Admission, handshake and stall decode.
    always_comb begin
        gate_open_s = &(ext_tready | ~ext_mask);
        full_s      = (count_q == LVL_W'(DEPTH));
        empty_s     = (count_q == LVL_W'(0));
        if (FRAME_MODE != 0) begin
            admit_s = (in_frame_q | gate_open_s) & ~full_s;
        end else begin
            admit_s = gate_open_s & ~full_s;
        end
        push_s  = in_tvalid & admit_s;
        pop_s   = ~empty_s & out_tready;
        stall_s = in_tvalid & ~full_s & ~admit_s;
    end

    // Next-state for pointers, occupancy, frame tracking and stall counter.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        in_frame_d  = in_frame_q;
        stall_cnt_d = stall_cnt_q;

        if (push_s) begin
            wr_ptr_d = ptr_inc(wr_ptr_q);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
        if (pop_s) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + LVL_W'(1);
            2'b01:   count_d = count_q - LVL_W'(1);
            default: count_d = count_q;
        endcase

        if (FRAME_MODE == 0) begin
            in_frame_d = 1'b0;
        end else if (push_s) begin
            in_frame_d = ~in_tlast;
        end else begin
            in_frame_d = in_frame_q;
        end

        // Clear wins over a coincident stall.
        if (cnt_clr) begin
            stall_cnt_d = 32'h0000_0000;
        end else if (stall_s && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Control state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= {PTR_W{1'b0}};
            rd_ptr_q    <= {PTR_W{1'b0}};
            count_q     <= {LVL_W{1'b0}};
            in_frame_q  <= 1'b0;
            stall_cnt_q <= 32'h0000_0000;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            in_frame_q  <= in_frame_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Beat storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {BEAT_W{1'b0}};
            end
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= {in_tlast, in_tid, in_tstrb, in_tuser, in_tdata};
        end
    end

    assign in_tready   = admit_s;
    assign stall_pulse = stall_s;
    assign stall_cnt   = stall_cnt_q;
    assign fifo_level  = count_q;
    assign out_tvalid  = ~empty_s;
    assign {out_tlast, out_tid, out_tstrb, out_tuser, out_tdata} = mem_q[rd_ptr_q];

endmodule

// File: doc/cr_ib_flow_gate.md
# cr_ib_flow_gate

Parametrised inbound flow gate for the engine's AXI4-Stream datapath. It sits between the inbound port and a core's TLV modules. Its per-beat admission check is the AND of several masked external-ready sources. In frame mode it never splits a frame. A DEPTH-entry elastic buffer decouples the gate from downstream backpressure, and the block counts gate-induced stall cycles.

## Interface
Parameters:
- DATA_W, 64, tdata width; tstrb width is DATA_W/8
- TID_W, 1, tid width
- TUSER_W, 8, tuser width
- N_EXT, 2, number of external ready sources (≥1)
- DEPTH, 4, buffer entries (≥2, any integer)
- FRAME_MODE, 0, 0 = beat-level gating, 1 = frame-level gating

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- in_tvalid / in_tlast  in  1 / 1  inbound stream valid, last
- in_tid / in_tstrb / in_tuser / in_tdata  in  TID_W / DATA_W/8 / TUSER_W / DATA_W  inbound payload
- in_tready  out  1  inbound ready
- ext_tready  in  N_EXT  external ready sources
- ext_mask  in  N_EXT  1 = source participates in gating (quasi-static config)
- out_tvalid / out_tlast  out  1 / 1  outbound stream valid, last
- out_tid / out_tstrb / out_tuser / out_tdata  out  as inbound  outbound payload
- out_tready  in  1  outbound ready
- stall_pulse  out  1  gate-induced stall this cycle
- stall_cnt  out  32  saturating stall-cycle count
- cnt_clr  in  1  synchronous clear of stall_cnt
- fifo_level  out  $clog2(DEPTH+1)  current occupancy

## Operation
- gate_open = &(ext_tready | ~ext_mask). ext_mask all zero means always open.
- Frame mode state in_frame:
  - Set on an accepted beat with tlast=0.
  - Cleared on an accepted beat with tlast=1.
  - Forced to 0 when FRAME_MODE=0.
- admit = (FRAME_MODE ? (in_frame | gate_open) : gate_open) & !full.
- in_tready = admit. It is combinational from registered state plus ext_tready/ext_mask.
- Accept: in_tvalid & in_tready. The full beat {tlast, tid, tstrb, tuser, tdata} is written at wr_ptr.
- Buffer is a circular array:
  - wr_ptr and rd_ptr run 0..DEPTH-1 and wrap to 0 after DEPTH-1.
  - Occupancy register count: full = (count==DEPTH), empty = (count==0).
- Simultaneous push and pop: count unchanged, both pointers advance.
- Full: in_tready=0 regardless of gate. A same-cycle pop does not re-open ready; there is no fall-through on full.
- out_tvalid = !empty. Output payload is the rd_ptr entry. Pop happens on out_tvalid & out_tready.
- stall_pulse = in_tvalid & !full & !admit, i.e. blocked by the gate only. It is 0 when blocked by full.
- stall_cnt:
  - +1 per stall_pulse cycle, saturates at 0xFFFFFFFF.
  - cnt_clr has priority: the counter reads 0 the cycle after clear, even if stall_pulse is 1 that cycle.
- Beat ordering and content are preserved exactly. No beat is dropped, duplicated or modified.
- fifo_level = count.

## Timing
- Reset values:
  - out_tvalid=0, fifo_level=0, stall_cnt=0, in_frame=0.
  - Pointers are 0. Payload outputs are don't-care/0.
  - in_tready follows gate_open.
- Reset mid-frame discards buffered beats and clears in_frame. The upstream must restart the frame.
- Latency: a beat accepted at cycle N drives out_tvalid at N+1 when the buffer was empty. Throughput is 1 beat/cycle when gate is open and out_tready=1.
- ext_tready falling at cycle N:
  - FRAME_MODE=0: in_tready=0 in cycle N.
  - FRAME_MODE=1 with in_frame=1: no effect until the tlast beat is accepted.
- Handshake:
  - out_tvalid never deasserts without a pop. Payload is stable while out_tvalid & !out_tready.
  - in_tvalid may be asserted independent of in_tready.

## Test plan
- Gate open, out_tready=1, DEPTH=4, 8-beat frame: output equals input beat-for-beat, first beat appears 1 cycle after accept, fifo_level ≤1, stall_cnt=0.
- FRAME_MODE=0, N_EXT=2, mask=2'b11:
  - Drop ext_tready[1] for 5 cycles mid-frame: in_tready=0 for exactly those 5 cycles, stall_cnt=5.
  - Repeat with mask=2'b01: no stall.
- FRAME_MODE=1: drop ext_tready mid-frame: frame completes through tlast, then in_tready=0 until ext_tready returns; stall_pulse counts only post-tlast cycles with in_tvalid=1.
- Hold out_tready=0 with a continuous input: fifo_level reaches DEPTH, in_tready=0, stall_pulse=0. Release: all DEPTH beats drain in order and pointers wrap correctly across 3×DEPTH beats.
- Counter checks:
  - Preload stall_cnt to 0xFFFFFFFE via 3 stalls over force: it saturates at 0xFFFFFFFF.
  - cnt_clr together with stall_pulse: stall_cnt=0 next cycle.
- Assert rst_n mid-frame with 3 beats buffered: out_tvalid=0 and fifo_level=0 immediately, in_frame cleared, a new frame passes cleanly after reset release.
